// File: rtl/sdram_upload_reader.sv
// Upload read path: turns data_io byte read strobes into SDRAM port1 word
// reads, with a one-word cache so the second byte of a word is served
// locally. Requests are level-held until acknowledged or timed out.
module sdram_upload_reader #(
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [7:0]  FILL    = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              din_valid,
  output logic              busy,
  output logic              error,
  output logic              port_req,
  input  logic              port_ack,
  output logic [ADDR_W-1:0] port_addr,
  output logic              port_we,
  output logic [1:0]        port_ds,
  input  logic [15:0]       port_q
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e            r_state, w_state_d;
  logic              r_rd_prev;
  logic              r_upload_prev;
  logic [7:0]        r_din, w_din_d;
  logic              r_din_valid, w_din_valid_d;
  logic              r_error, w_error_d;
  logic              r_req, w_req_d;
  logic [ADDR_W-1:0] r_port_addr, w_port_addr_d;
  logic              r_byte_sel, w_byte_sel_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [15:0]       r_cache_word, w_cache_word_d;
  logic [ADDR_W-1:0] r_cache_addr, w_cache_addr_d;
  logic              r_cache_valid, w_cache_valid_d;
  logic              r_abort, w_abort_d;
  // A start landing on the cycle a result is presented is deferred one cycle
  // so din_valid never pulses back-to-back.
  logic              r_pend, w_pend_d;
  logic [ADDR_W:0]   r_pend_addr, w_pend_addr_d;

  logic              w_start;
  logic [ADDR_W:0]   w_sel_addr;
  logic              w_hit;
  logic [7:0]        w_cached_byte;
  logic [7:0]        w_ack_byte;
  logic              w_done;
  logic              w_unused;

  // Only the word/byte address bits within ADDR_W are meaningful.
  assign w_unused = ^ioctl_addr;

  assign w_start       = ioctl_rd & ~r_rd_prev & ioctl_upload;
  assign w_sel_addr    = r_pend ? r_pend_addr : ioctl_addr[ADDR_W:0];
  assign w_hit         = r_cache_valid && (w_sel_addr[ADDR_W:1] == r_cache_addr);
  assign w_cached_byte = w_sel_addr[0] ? r_cache_word[15:8] : r_cache_word[7:0];
  assign w_ack_byte    = r_byte_sel ? port_q[15:8] : port_q[7:0];
  assign w_done        = port_ack || (r_cnt == CntW'(TIMEOUT - 1));

  // Next-state and next-output decode for the request FSM and its datapath.
  always_comb begin
    w_state_d       = r_state;
    w_din_d         = r_din;
    w_din_valid_d   = 1'b0;
    w_error_d       = r_error;
    w_req_d         = r_req;
    w_port_addr_d   = r_port_addr;
    w_byte_sel_d    = r_byte_sel;
    w_cnt_d         = r_cnt;
    w_cache_word_d  = r_cache_word;
    w_cache_addr_d  = r_cache_addr;
    w_cache_valid_d = r_cache_valid;
    w_abort_d       = r_abort;
    w_pend_d        = r_pend;
    w_pend_addr_d   = r_pend_addr;

    // A new session starts with a clean error flag; later sets override.
    if (ioctl_upload && !r_upload_prev) begin
      w_error_d = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (!ioctl_upload) begin
          w_cache_valid_d = 1'b0;
          w_error_d       = 1'b0;
          w_pend_d        = 1'b0;
        end else if (w_start || r_pend) begin
          if (r_din_valid) begin
            w_pend_d      = 1'b1;
            w_pend_addr_d = ioctl_addr[ADDR_W:0];
          end else begin
            w_pend_d = 1'b0;
            if (w_hit) begin
              w_din_d       = w_cached_byte;
              w_din_valid_d = 1'b1;
            end else begin
              w_req_d       = 1'b1;
              w_port_addr_d = w_sel_addr[ADDR_W:1];
              w_byte_sel_d  = w_sel_addr[0];
              w_cnt_d       = '0;
              w_abort_d     = 1'b0;
              w_state_d     = StReq;
            end
          end
        end
      end

      StReq: begin
        if (!ioctl_upload) begin
          w_abort_d = 1'b1;
        end else if (w_start) begin
          w_error_d = 1'b1;
        end

        if (w_done) begin
          w_req_d   = 1'b0;
          w_state_d = StIdle;
          if (r_abort || !ioctl_upload) begin
            // Session ended mid-request: finish the handshake silently.
            w_cache_valid_d = 1'b0;
            w_error_d       = 1'b0;
          end else if (port_ack) begin
            w_cache_word_d  = port_q;
            w_cache_addr_d  = r_port_addr;
            w_cache_valid_d = 1'b1;
            w_din_d         = w_ack_byte;
            w_din_valid_d   = 1'b1;
          end else begin
            w_din_d       = FILL;
            w_din_valid_d = 1'b1;
            w_error_d     = 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end

      default: begin
        w_state_d = StIdle;
        w_req_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state       <= StIdle;
      r_rd_prev     <= 1'b0;
      r_upload_prev <= 1'b0;
      r_din         <= '0;
      r_din_valid   <= 1'b0;
      r_error       <= 1'b0;
      r_req         <= 1'b0;
      r_port_addr   <= '0;
      r_byte_sel    <= 1'b0;
      r_cnt         <= '0;
      r_cache_word  <= '0;
      r_cache_addr  <= '0;
      r_cache_valid <= 1'b0;
      r_abort       <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_addr   <= '0;
    end else begin
      r_state       <= w_state_d;
      r_rd_prev     <= ioctl_rd;
      r_upload_prev <= ioctl_upload;
      r_din         <= w_din_d;
      r_din_valid   <= w_din_valid_d;
      r_error       <= w_error_d;
      r_req         <= w_req_d;
      r_port_addr   <= w_port_addr_d;
      r_byte_sel    <= w_byte_sel_d;
      r_cnt         <= w_cnt_d;
      r_cache_word  <= w_cache_word_d;
      r_cache_addr  <= w_cache_addr_d;
      r_cache_valid <= w_cache_valid_d;
      r_abort       <= w_abort_d;
      r_pend        <= w_pend_d;
      r_pend_addr   <= w_pend_addr_d;
    end
  end

  assign ioctl_din = r_din;
  assign din_valid = r_din_valid;
  assign busy      = (r_state == StReq);
  assign error     = r_error;
  assign port_req  = r_req;
  assign port_addr = r_port_addr;
  assign port_we   = 1'b0;
  assign port_ds   = 2'b11;

endmodule

// File: tb/tb_sdram_upload_reader.sv
// Directed bench for sdram_upload_reader: a transaction-level model predicts
// every registered output each cycle; directed steps add literal checks.
module tb_sdram_upload_reader;

  localparam int unsigned AW = 22;
  localparam int unsigned TO = 16;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          din_valid;
  logic          busy;
  logic          error;
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_addr;
  logic          port_we;
  logic [1:0]    port_ds;
  logic [15:0]   port_q;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_upload_reader #(
    .ADDR_W (AW),
    .TIMEOUT(TO),
    .FILL   (8'hFF)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .din_valid   (din_valid),
    .busy        (busy),
    .error       (error),
    .port_req    (port_req),
    .port_ack    (port_ack),
    .port_addr   (port_addr),
    .port_we     (port_we),
    .port_ds     (port_ds),
    .port_q      (port_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding transaction, a one-word cache, and edge-cycle stamps.
  int           cyc = 0;
  bit           m_prev_rd, m_prev_up;
  bit           t_active, t_aborted;
  int           t_issue;
  logic [AW:0]  t_baddr;
  bit           c_valid;
  logic [AW-1:0] c_addr;
  logic [15:0]  c_word;
  bit           e_req, e_err, e_dv;
  logic [7:0]   e_din;
  logic [AW-1:0] e_paddr;

  function automatic logic [7:0] pick(input logic [15:0] w, input logic b);
    return b ? w[15:8] : w[7:0];
  endfunction

  task automatic model_step();
    bit          start;
    logic [AW:0] ba;
    cyc++;
    if (reset) begin
      m_prev_rd = 0; m_prev_up = 0; t_active = 0; t_aborted = 0;
      c_valid = 0; e_req = 0; e_err = 0; e_dv = 0; e_din = 8'h00; e_paddr = '0;
      return;
    end
    start = ioctl_rd && !m_prev_rd && ioctl_upload;
    ba    = ioctl_addr[AW:0];
    e_dv  = 0;
    if (ioctl_upload && !m_prev_up) e_err = 0;
    if (t_active) begin
      if (!ioctl_upload) t_aborted = 1;
      else if (start) e_err = 1;
      if (port_ack || (cyc - t_issue) == TO) begin
        t_active = 0;
        e_req    = 0;
        if (t_aborted) begin
          c_valid = 0;
          e_err   = 0;
        end else if (port_ack) begin
          c_valid = 1; c_word = port_q; c_addr = t_baddr[AW:1];
          e_dv = 1; e_din = pick(port_q, t_baddr[0]);
        end else begin
          e_dv = 1; e_din = 8'hFF; e_err = 1;
        end
      end
    end else if (!ioctl_upload) begin
      c_valid = 0;
      e_err   = 0;
    end else if (start) begin
      if (c_valid && c_addr == ba[AW:1]) begin
        e_dv = 1; e_din = pick(c_word, ba[0]);
      end else begin
        t_active = 1; t_aborted = 0; t_issue = cyc; t_baddr = ba;
        e_req = 1; e_paddr = ba[AW:1];
      end
    end
    m_prev_rd = ioctl_rd;
    m_prev_up = ioctl_upload;
  endtask

  initial begin
    forever begin
      @(posedge clk_sys);
      model_step();
    end
  end

  // Per-cycle compare, sampled shortly after the active edge.
  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      chk("cyc_port_req", port_req, e_req);
      chk("cyc_busy", busy, t_active);
      chk("cyc_error", error, e_err);
      chk("cyc_din_valid", din_valid, e_dv);
      if (e_dv) chk("cyc_ioctl_din", ioctl_din, e_din);
      if (e_req) chk("cyc_port_addr", port_addr, e_paddr);
      chk("cyc_port_we", port_we, 1'b0);
      chk("cyc_port_ds", port_ds, 2'b11);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Raise rd for one cycle; returns after the edge has been sampled.
  task automatic rd_edge(input logic [24:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    ioctl_rd   = 1'b0;
  endtask

  task automatic ack_once(input logic [15:0] q);
    port_q   = q;
    port_ack = 1'b1;
    @(negedge clk_sys);
    port_ack = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    port_ack = 1'b0; port_q = 16'h0000;
    tick(3);
    chk("rst_port_req", port_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_din_valid", din_valid, 1'b0);
    chk("rst_ioctl_din", ioctl_din, 8'h00);
    chk("rst_port_addr", port_addr, 22'h0);
    reset = 1'b0;
    ioctl_upload = 1'b1;
    tick(2);

    // Miss on 0x100, ack three cycles after req.
    rd_edge(25'h000100);
    chk("miss_req", port_req, 1'b1);
    chk("miss_paddr", port_addr, 22'h000080);
    chk("miss_busy", busy, 1'b1);
    tick(2);
    chk("miss_req_held", port_req, 1'b1);
    ack_once(16'hBEEF);
    chk("miss_din", ioctl_din, 8'hEF);
    chk("miss_dv", din_valid, 1'b1);
    chk("miss_req_low", port_req, 1'b0);
    tick(1);

    // Hit on the odd byte of the cached word.
    rd_edge(25'h000101);
    chk("hit_din", ioctl_din, 8'hBE);
    chk("hit_dv", din_valid, 1'b1);
    chk("hit_no_req", port_req, 1'b0);
    tick(2);

    // Timeout: no ack.
    rd_edge(25'h000200);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      if (!port_req) break;
      @(negedge clk_sys);
      if (port_req) n++;
    end
    chk("to_req_cycles", n, TO);
    chk("to_din", ioctl_din, 8'hFF);
    chk("to_dv", din_valid, 1'b1);
    chk("to_error", error, 1'b1);
    tick(1);
    rd_edge(25'h000200);
    chk("to_retry_req", port_req, 1'b1);
    tick(1);
    ack_once(16'h1234);
    chk("to_retry_din", ioctl_din, 8'h34);
    chk("to_error_sticky", error, 1'b1);
    tick(1);

    // New session clears error.
    ioctl_upload = 1'b0;
    tick(2);
    ioctl_upload = 1'b1;
    tick(2);
    chk("sess_error_clr", error, 1'b0);

    // Overrun: second edge while the first request is in flight.
    rd_edge(25'h000300);
    ioctl_addr = 25'h000302;
    tick(1);
    ioctl_rd = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    chk("ovr_error", error, 1'b1);
    chk("ovr_paddr", port_addr, 22'h000180);
    ack_once(16'hA5C3);
    chk("ovr_din", ioctl_din, 8'hC3);
    tick(4);
    chk("ovr_single_dv", din_valid, 1'b0);

    // Upload ends mid-request.
    rd_edge(25'h000100);
    ioctl_upload = 1'b0;
    tick(2);
    ack_once(16'h5566);
    chk("end_no_dv", din_valid, 1'b0);
    chk("end_req_low", port_req, 1'b0);
    tick(1);
    ioctl_upload = 1'b1;
    tick(2);
    rd_edge(25'h000101);
    chk("end_new_miss", port_req, 1'b1);
    tick(1);
    ack_once(16'h7788);
    chk("end_new_din", ioctl_din, 8'h77);
    chk("end_error", error, 1'b0);
    tick(2);

    // Reset mid-request, then a late ack.
    rd_edge(25'h000400);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("rmid_req", port_req, 1'b0);
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_dv", din_valid, 1'b0);
    reset = 1'b0;
    port_ack = 1'b1;
    tick(2);
    port_ack = 1'b0;
    chk("late_ack_dv", din_valid, 1'b0);
    chk("late_ack_req", port_req, 1'b0);
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_upload_reader.md
Name: sdram_upload_reader

Overview:
- Read-side counterpart of the ROM download path: serves ioctl upload byte reads (e.g. hiscore/NVRAM save to the SD card) from SDRAM port1.
- Converts byte read strobes from data_io into word-wide port1 read requests (level req, cleared on ack).
- Keeps a one-word cache so the odd byte of a word never issues a second SDRAM access.
- Sits between data_io and scandoubler_sdram port1, alongside the download write logic.

Parameters:
- ADDR_W, 22, port1 word address width (byte address bits [ADDR_W:1])
- TIMEOUT, 1023, cycles to wait for port_ack before aborting a request
- FILL, 8'hFF, byte returned on timeout

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ioctl_upload  in  1  upload session active
- ioctl_rd  in  1  byte read strobe from data_io (level, edge-detected)
- ioctl_addr  in  25  byte address of requested byte
- ioctl_din  out  8  returned byte
- din_valid  out  1  one-cycle pulse, ioctl_din valid
- busy  out  1  request in flight
- error  out  1  sticky: timeout or overrun since upload start
- port_req  out  1  SDRAM port1 request, held until ack
- port_ack  in  1  SDRAM port1 acknowledge
- port_addr  out  ADDR_W  word address = ioctl_addr[ADDR_W:1]
- port_we  out  1  constant 0 (read)
- port_ds  out  2  constant 2'b11
- port_q  in  16  read word; byte 0 in [7:0], byte 1 in [15:8]

Behaviour:
- Reset values: ioctl_din=0, din_valid=0, busy=0, error=0, port_req=0, port_addr=0, cache_valid=0, state IDLE.
- Start condition: rising edge of ioctl_rd (registered previous value) while ioctl_upload=1. Edges while ioctl_upload=0 are ignored.
- FSM states:
  - IDLE: start seen at cycle N.
    - Hit (cache_valid and addr[ADDR_W:1]==cache_addr): at N+1 ioctl_din = byte addr[0] of cached word, din_valid=1, no port_req.
    - Miss: at N+1 port_req=1, port_addr latched, busy=1, timeout counter cleared; go REQ.
  - REQ: port_req held high.
    - On cycle M with port_ack=1: capture port_q into cache, set cache_addr, cache_valid=1.
    - At M+1: port_req=0, ioctl_din=selected byte, din_valid=1, busy=0; go IDLE.
    - Miss latency: 1 cycle + ack wait + 1 cycle.
    - If the counter reaches TIMEOUT-1 without ack: next cycle port_req=0, ioctl_din=FILL, din_valid=1, error=1, busy=0, cache unchanged; go IDLE.
- Start edge while busy (REQ): ignored, error=1 (overrun); the current request is unaffected.
- ioctl_upload falling:
  - In IDLE: cache_valid=0 and error=0 next cycle.
  - In REQ: the handshake runs to completion (ack or timeout), port_req drops normally, din_valid is suppressed, result is not cached, then cache_valid=0 and error=0.
- ioctl_upload rising clears error.
- Reset mid-REQ: port_req=0 on the next edge and all state returns to reset values. A late port_ack while in IDLE is ignored.
- din_valid is never asserted on two consecutive cycles. port_addr is stable while port_req=1.

Test Plan:
- Miss: upload=1, addr=0x000100, rd rises; model acks 3 cycles after req with port_q=0xBEEF -> req high 1 cycle after the edge and held until ack, port_addr=0x80, ioctl_din=0xEF with din_valid 1 cycle after ack, req low.
- Hit: following that, rd for addr 0x000101 -> ioctl_din=0xBE, din_valid 1 cycle after the edge, port_req never asserted.
- Timeout: TIMEOUT=16, no ack -> port_req high exactly 16 cycles then low, ioctl_din=0xFF, din_valid=1, error=1; the next read of the same address issues a new request.
- Overrun: second rd edge 1 cycle into a REQ -> only one din_valid pulse (for the first address), error=1.
- Upload end: drop ioctl_upload during REQ, ack arrives -> no din_valid, req drops; a new session reading addr 0x000101 misses and requests again, error=0.
- Reset mid-REQ: reset asserted 2 cycles after req -> req=0, busy=0, din_valid=0 next cycle; late ack produces no output.
